// File: rtl/pi_loop_sequencer_if.sv
// Signal bundle between the PI loop sequencer, the PI pipeline and the DAC driver.
// The master side is the sequencer; the slave side is the pipeline/DAC environment.
interface pi_loop_sequencer_if #(
  parameter int OUTPUT_WIDTH      = 32,
  parameter int OUTPUT_RANGE_BITS = 20
);
  logic                         pipe_start;
  logic                         pipe_result_valid;
  logic [OUTPUT_WIDTH-1:0]      pipe_integral_result;
  logic [OUTPUT_WIDTH-1:0]      pipe_pi_result;
  logic                         pipe_overflow;
  logic                         pipe_underflow;
  logic [OUTPUT_WIDTH-1:0]      integral_state;
  logic [OUTPUT_RANGE_BITS-1:0] dac_data;
  logic                         dac_req;
  logic                         dac_ack;

  modport master (
    output pipe_start,
    input  pipe_result_valid,
    input  pipe_integral_result,
    input  pipe_pi_result,
    input  pipe_overflow,
    input  pipe_underflow,
    output integral_state,
    output dac_data,
    output dac_req,
    input  dac_ack
  );

  modport slave (
    input  pipe_start,
    output pipe_result_valid,
    output pipe_integral_result,
    output pipe_pi_result,
    output pipe_overflow,
    output pipe_underflow,
    input  integral_state,
    input  dac_data,
    input  dac_req,
    output dac_ack
  );
endinterface

// File: rtl/pi_loop_sequencer.sv
// Per-sample sequencer around the PI pipeline: start, wait, clamp,
// anti-windup integral update and a four-phase DAC write.
module pi_loop_sequencer #(
  parameter int OUTPUT_WIDTH      = 32,
  parameter int OUTPUT_RANGE_BITS = 20,
  parameter int PIPE_TIMEOUT      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                integral_clear,
  input  logic                sample_ready,
  pi_loop_sequencer_if.master bus,
  output logic                busy,
  output logic [31:0]         sample_count,
  output logic [15:0]         sat_count,
  output logic                missed_sample,
  output logic                pipe_fault
);

  localparam int W  = OUTPUT_WIDTH;
  localparam int R  = OUTPUT_RANGE_BITS;
  localparam int CW = $clog2(PIPE_TIMEOUT + 1);

  localparam logic [CW-1:0] TMO_LAST =
    CW'(PIPE_TIMEOUT - 1);

  localparam logic [R-1:0] DAC_MAX =
    {1'b0, {(R-1){1'b1}}};
  localparam logic [R-1:0] DAC_MIN =
    {1'b1, {(R-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_PIPE,
    UPDATE,
    DAC_REQ,
    DAC_RELEASE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] tmo_cnt;
  logic [R-1:0]  cap_pi;
  logic [W-1:0]  cap_int;
  logic          cap_ovf;
  logic          cap_unf;
  logic [R-1:0]  dac_q;
  logic [W-1:0]  integ_q;

  logic          start_c;
  logic          req_c;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          capture;
  logic          do_update;
  logic          fault_set;
  logic          clr_integ;
  logic          sat_flag;
  logic [R-1:0]  dac_nx;
  logic          unused_pi_hi;

  // High result bits are dropped; the pipeline flags carry range info.
  assign unused_pi_hi =
    ^bus.pipe_pi_result[W-1:R];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    start_c   = 1'b0;
    req_c     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    do_update = 1'b0;
    fault_set = 1'b0;
    clr_integ = 1'b0;
    unique case (state)
      IDLE: begin
        clr_integ = integral_clear;
        if (enable && sample_ready) begin
          state_nx = START;
        end
      end
      START: begin
        start_c  = 1'b1;
        cnt_clr  = 1'b1;
        state_nx = WAIT_PIPE;
      end
      WAIT_PIPE: begin
        // First wait cycle is blind: the tracker clears on that edge.
        if (tmo_cnt != '0 &&
            bus.pipe_result_valid) begin
          capture  = 1'b1;
          state_nx = UPDATE;
        end else if (tmo_cnt == TMO_LAST) begin
          fault_set = 1'b1;
          state_nx  = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      UPDATE: begin
        do_update = 1'b1;
        state_nx  = DAC_REQ;
      end
      DAC_REQ: begin
        req_c = 1'b1;
        if (bus.dac_ack) begin
          state_nx = DAC_RELEASE;
        end
      end
      DAC_RELEASE: begin
        if (!bus.dac_ack) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    sat_flag = cap_ovf | cap_unf;
    dac_nx   = cap_pi;
    unique case (1'b1)
      cap_ovf: dac_nx = DAC_MAX;
      cap_unf: dac_nx = DAC_MIN;
      default: dac_nx = cap_pi;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (cnt_clr) begin
      tmo_cnt <= '0;
    end else if (cnt_inc) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_pi  <= '0;
      cap_int <= '0;
      cap_ovf <= 1'b0;
      cap_unf <= 1'b0;
    end else if (capture) begin
      cap_pi  <= bus.pipe_pi_result[R-1:0];
      cap_int <= bus.pipe_integral_result;
      cap_ovf <= bus.pipe_overflow;
      cap_unf <= bus.pipe_underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q <= '0;
    end else if (clr_integ) begin
      integ_q <= '0;
    end else if (do_update && !sat_flag) begin
      integ_q <= cap_int;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_q        <= '0;
      sample_count <= '0;
      sat_count    <= '0;
    end else if (do_update) begin
      dac_q        <= dac_nx;
      sample_count <= sample_count + 32'd1;
      if (sat_flag && sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_fault    <= 1'b0;
      missed_sample <= 1'b0;
    end else begin
      if (fault_set) begin
        pipe_fault <= 1'b1;
      end
      if (sample_ready && state != IDLE) begin
        missed_sample <= 1'b1;
      end
    end
  end

  assign bus.pipe_start     = start_c;
  assign bus.dac_req        = req_c;
  assign bus.dac_data       = dac_q;
  assign bus.integral_state = integ_q;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Scoreboard bench for pi_loop_sequencer: directed iterations with
// hand-computed DAC/integral/counter results checked on each DAC request.
module tb_pi_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        integral_clear = 1'b0;
  logic        sample_ready = 1'b0;
  logic        busy;
  logic [31:0] sample_count;
  logic [15:0] sat_count;
  logic        missed_sample;
  logic        pipe_fault;

  pi_loop_sequencer_if #(
    .OUTPUT_WIDTH(32),
    .OUTPUT_RANGE_BITS(20)
  ) bus ();

  pi_loop_sequencer #(
    .OUTPUT_WIDTH(32),
    .OUTPUT_RANGE_BITS(20),
    .PIPE_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .integral_clear(integral_clear),
    .sample_ready(sample_ready),
    .bus(bus),
    .busy(busy),
    .sample_count(sample_count),
    .sat_count(sat_count),
    .missed_sample(missed_sample),
    .pipe_fault(pipe_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] dac;
    logic [31:0] integ;
    logic [31:0] sc;
    logic [15:0] sat;
    int          rcyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int s_cyc = 0;
  int n_start = 0;
  int ack_delay = 1;
  bit pipe_mute = 1'b0;
  bit req_dropped = 1'b0;
  bit dac_abort = 1'b0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h",
               name, act, req);
    end
  endtask

  // Monitor: each rising dac_req pops one expected iteration.
  always @(negedge clk) begin
    if (bus.dac_req && !prev_req) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_dac_req: got request at cycle %0d, required none",
                 cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("dac_data", 32'(bus.dac_data), 32'(mon_e.dac));
        check("integral_state", bus.integral_state, mon_e.integ);
        check("sample_count", sample_count, mon_e.sc);
        check("sat_count", 32'(sat_count), 32'(mon_e.sat));
        check("dac_req_cycle", 32'(cyc), 32'(mon_e.rcyc));
      end
    end
    prev_req = bus.dac_req;
  end

  // Pipeline model: result_valid five cycles after the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pipe_start) begin
        n_start++;
        check("pipe_start_cycle", 32'(cyc), 32'(s_cyc + 1));
        if (!pipe_mute) begin
          repeat (5) @(posedge clk);
          #1 bus.pipe_result_valid = 1'b1;
          @(posedge clk);
          #1 bus.pipe_result_valid = 1'b0;
        end
      end
    end
  end

  // DAC model: ack after ack_delay cycles, release when req drops.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.dac_req && !bus.dac_ack) begin
        dac_abort = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge clk);
          #1;
          if (!bus.dac_req) begin
            dac_abort = 1'b1;
            break;
          end
        end
        if (dac_abort) begin
          req_dropped = 1'b1;
        end else begin
          bus.dac_ack = 1'b1;
          for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.dac_req) break;
          end
          bus.dac_ack = 1'b0;
        end
      end
    end
  end

  task automatic issue_sample();
    @(posedge clk);
    #1 sample_ready = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1 sample_ready = 1'b0;
  endtask

  task automatic push_exp(input logic [19:0] d,
                          input logic [31:0] ig,
                          input logic [31:0] sc,
                          input logic [15:0] st);
    exp_t e;
    e.dac = d;
    e.integ = ig;
    e.sc = sc;
    e.sat = st;
    e.rcyc = s_cyc + 8;
    sbq.push_back(e);
  endtask

  task automatic set_pipe(input logic [31:0] pi,
                          input logic [31:0] ig,
                          input logic ovf,
                          input logic unf);
    bus.pipe_pi_result = pi;
    bus.pipe_integral_result = ig;
    bus.pipe_overflow = ovf;
    bus.pipe_underflow = unf;
  endtask

  task automatic wait_idle(output int done);
    done = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !bus.dac_ack) begin
        done = cyc;
        break;
      end
    end
    if (done < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: got busy after 100 cycles, required idle");
    end
  endtask

  task automatic run_iter(input logic [31:0] pi,
                          input logic [31:0] ig,
                          input logic ovf,
                          input logic unf,
                          input logic [19:0] edac,
                          input logic [31:0] eig,
                          input logic [31:0] esc,
                          input logic [15:0] esat);
    int st0;
    int done;
    st0 = n_start;
    set_pipe(pi, ig, ovf, unf);
    issue_sample();
    push_exp(edac, eig, esc, esat);
    wait_idle(done);
    check("pipe_start_pulses", 32'(n_start - st0), 32'd1);
    check("iteration_cycles", 32'(done - s_cyc), 32'd11);
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dac_req", 32'(bus.dac_req), 32'd0);
    check("rst_pipe_start", 32'(bus.pipe_start), 32'd0);
    check("rst_dac_data", 32'(bus.dac_data), 32'd0);
    check("rst_integral", bus.integral_state, 32'd0);
    check("rst_sample_count", sample_count, 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_missed", 32'(missed_sample), 32'd0);
    check("rst_fault", 32'(pipe_fault), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1 ms, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done;
    bus.pipe_result_valid = 1'b0;
    bus.dac_ack = 1'b0;
    set_pipe(32'h0, 32'h0, 1'b0, 1'b0);

    #3;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);

    run_iter(32'h0000_1234, 32'h10, 1'b0, 1'b0,
             20'h01234, 32'h10, 32'd1, 16'd0);
    check("missed_clean", 32'(missed_sample), 32'd0);

    run_iter(32'h7FFF_FFFF, 32'h999, 1'b1, 1'b0,
             20'h7FFFF, 32'h10, 32'd2, 16'd1);

    run_iter(32'hFFF0_0000, 32'h555, 1'b0, 1'b1,
             20'h80000, 32'h10, 32'd3, 16'd2);

    run_iter(32'hFFFF_FFF0, 32'hFFFF_FF00, 1'b0, 1'b0,
             20'hFFFF0, 32'hFFFF_FF00, 32'd4, 16'd2);

    // Slow DAC with a sample arriving mid-handshake.
    ack_delay = 20;
    req_dropped = 1'b0;
    set_pipe(32'h0005_5555, 32'h20, 1'b0, 1'b0);
    issue_sample();
    push_exp(20'h55555, 32'h20, 32'd5, 16'd2);
    repeat (12) @(posedge clk);
    #1 sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    wait_idle(done);
    check("slow_iter_cycles", 32'(done - s_cyc), 32'd30);
    check("slow_req_held", 32'(req_dropped), 32'd0);
    check("slow_missed", 32'(missed_sample), 32'd1);
    check("slow_sample_count", sample_count, 32'd5);
    ack_delay = 1;

    // Pipeline timeout.
    pipe_mute = 1'b1;
    set_pipe(32'h1, 32'hDEAD, 1'b0, 1'b0);
    issue_sample();
    while (cyc < s_cyc + 9) @(negedge clk);
    check("tmo_fault_early", 32'(pipe_fault), 32'd0);
    check("tmo_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_fault", 32'(pipe_fault), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_integral", bus.integral_state, 32'h20);
    check("tmo_sample_count", sample_count, 32'd5);
    pipe_mute = 1'b0;

    // Integral clear in IDLE.
    @(posedge clk);
    #1 integral_clear = 1'b1;
    @(posedge clk);
    #1 integral_clear = 1'b0;
    @(negedge clk);
    check("clear_integral", bus.integral_state, 32'd0);

    // Reset in the middle of the DAC handshake.
    ack_delay = 30;
    req_dropped = 1'b0;
    set_pipe(32'h42, 32'h77, 1'b0, 1'b0);
    issue_sample();
    push_exp(20'h00042, 32'h77, 32'd6, 16'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.dac_req) break;
    end
    #2 rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1;
    repeat (3) @(posedge clk);
    check("rst_req_aborted", 32'(req_dropped), 32'd1);

    run_iter(32'h0000_0ABC, 32'h30, 1'b0, 1'b0,
             20'h00ABC, 32'h30, 32'd1, 16'd0);
    check("post_rst_fault", 32'(pipe_fault), 32'd0);
    check("post_rst_missed", 32'(missed_sample), 32'd0);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pi_loop_sequencer.md
# pi_loop_sequencer

Sequencer and output stage wrapped around `pi_pipeline`. On each new ADC sample it issues the pipeline start pulse and waits for `result_valid`. It then clamps the PI result to the DAC range, updates the integral state with anti-windup, and writes the clamped value to the DAC over a four-phase req/ack handshake. It sits between the ADC sample strobe, the PI pipeline and the DAC driver.

## Interface
- `OUTPUT_WIDTH`, 32: width of the PI pipeline's integral and result buses.
- `OUTPUT_RANGE_BITS`, 20: signed DAC code width; must match `pi_pipeline`.
- `PIPE_TIMEOUT`, 8: maximum cycles from `pipe_start` to `pipe_result_valid` before a fault.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  loop run enable.
- `integral_clear`  in  1  synchronous pulse; zeroes `integral_state` when in IDLE.
- `sample_ready`  in  1  one-cycle strobe: new ADC `actual` is valid on the pipeline inputs.
- `pipe_start`  out  1  start pulse to the pipeline.
- `pipe_result_valid`  in  1  pipeline `result_valid`.
- `pipe_integral_result`  in  OUTPUT_WIDTH  pipeline `integral_result`.
- `pipe_pi_result`  in  OUTPUT_WIDTH  pipeline `pi_result`.
- `pipe_overflow`, `pipe_underflow`  in  1  pipeline saturation flags.
- `integral_state`  out  OUTPUT_WIDTH  registered integral, fed to the pipeline's `integral_input`.
- `dac_data`  out  OUTPUT_RANGE_BITS  clamped two's-complement code.
- `dac_req`  out  1  DAC write request.
- `dac_ack`  in  1  DAC acknowledge.
- `busy`  out  1  high when not in IDLE.
- `sample_count`  out  32  number of completed loop iterations; wraps.
- `sat_count`  out  16  number of saturated iterations; saturates at 0xFFFF.
- `missed_sample`  out  1  sticky; cleared by `rst` only.
- `pipe_fault`  out  1  sticky; cleared by `rst` only.

## Operation
- The states are IDLE, START, WAIT_PIPE, UPDATE, DAC_REQ and DAC_RELEASE.
- IDLE:
  - If `enable` and `sample_ready`, go to START.
  - If `integral_clear` is high, `integral_state` becomes 0.
- START:
  - `pipe_start` is 1 for this one cycle only; it is 0 in every other state.
  - Go to WAIT_PIPE and load the timeout counter with 0.
- WAIT_PIPE:
  - `pipe_result_valid` is ignored in the first WAIT_PIPE cycle, because the pipeline clears its tracker on that edge.
  - From the second WAIT_PIPE cycle, `pipe_result_valid=1` moves to UPDATE and captures `pipe_pi_result`, `pipe_integral_result` and both flags.
  - When the counter reaches `PIPE_TIMEOUT`, set `pipe_fault`, do not update state, and go to IDLE.
- UPDATE:
  - If overflow: `dac_data` = 2^(R-1)-1.
  - Else if underflow: `dac_data` = -2^(R-1).
  - Otherwise: `dac_data` = `pipe_pi_result[R-1:0]`.
  - R = OUTPUT_RANGE_BITS.
  - Anti-windup:
    - `integral_state` takes the captured `pipe_integral_result` only if neither flag is set.
    - If a flag is set, `integral_state` holds and `sat_count` increments, saturating.
  - `sample_count` increments.
  - Go to DAC_REQ.
- DAC_REQ:
  - `dac_req` = 1.
  - When `dac_ack` is sampled 1, drop `dac_req` and go to DAC_RELEASE.
- DAC_RELEASE:
  - Wait for `dac_ack` = 0, then go to IDLE.
- `sample_ready` in any state other than IDLE sets `missed_sample`; the sample is dropped.
- `enable` falling mid-iteration does not abort the iteration. The current iteration completes, including the DAC handshake; no new iteration starts.
- `integral_clear` outside IDLE is ignored.

## Timing
- All outputs reset to 0, and the state resets to IDLE.
- `integral_state` is stable from START through WAIT_PIPE; the pipeline samples it one cycle after START.
- Define cycle S as the cycle in which `sample_ready` is seen in IDLE:
  - START is cycle S+1.
  - With `pipeline_tracker`, `pipe_result_valid` rises in cycle S+6.
  - UPDATE is cycle S+7.
  - `dac_data`, `integral_state` and the counters are valid and `dac_req` rises in cycle S+8.
- With `dac_ack` returned one cycle after `dac_req` and dropped the cycle after `dac_req` falls, the iteration returns to IDLE at S+11. That is the minimum sample period of 11 cycles.
- `dac_data` holds its value until the next UPDATE.
- `rst` is asynchronous and can arrive mid-operation. It immediately forces IDLE, `dac_req`=0 and `pipe_start`=0, and zeroes every register.

## Test plan
- Nominal run with R=20:
  - Stimulus: `pipe_pi_result`=0x00001234, no flags, `pipe_integral_result`=0x10, with `sample_ready` at S.
  - Required: `pipe_start` only at S+1; `dac_data`=0x01234; `integral_state`=0x10 and `sample_count`=1 at S+8; `dac_req` high until ack.
- Overflow:
  - Stimulus: `pipe_overflow`=1, `pipe_integral_result`=0x999.
  - Required: `dac_data`=0x7FFFF; `integral_state` unchanged; `sat_count`=1.
- Underflow:
  - Stimulus: `pipe_underflow`=1.
  - Required: `dac_data`=0x80000; `integral_state` held; `sat_count` increments.
- Slow DAC:
  - Stimulus: `dac_ack` asserted 20 cycles after `dac_req`, and a `sample_ready` pulse during the wait.
  - Required: `dac_req` held for all 20 cycles; `missed_sample`=1; `sample_count` advances by 1 only.
- Pipeline timeout:
  - Stimulus: `pipe_result_valid` held 0.
  - Required: `pipe_fault`=1 after 8 WAIT_PIPE cycles; return to IDLE with no DAC request; `integral_state` unchanged.
- Reset mid-handshake:
  - Stimulus: `rst` pulsed while `dac_req`=1.
  - Required: `dac_req`, `busy`, `dac_data`, the counters and the sticky flags all go to 0 asynchronously; the next `sample_ready` runs a normal iteration.
